// File: rtl/pwm_duty_capture.sv
// PWM receiver: measures period and high time, derives duty percent and humidity band, flags stuck lines.
// Optional glitch filter on the synchronized input: define PWM_GLITCH_FILTER_EN.
module pwm_duty_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic [1:0]       band,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             busy
);

  // valid is a one-cycle strobe with no back-pressure: the other outputs are stable from that cycle until the next strobe.
  localparam int DW = CNT_W + 7;
  localparam logic [1:0] ST_WAIT_RISE = 2'd0;
  localparam logic [1:0] ST_MEASURE   = 2'd1;
  localparam logic [1:0] ST_DIVIDE    = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  if (FILTER_LEN < 2 || FILTER_LEN > 15 || TIMEOUT < 1) begin : g_bad_params
    $error("pwm_duty_capture: FILTER_LEN or TIMEOUT out of range");
  end

  function automatic logic [1:0] band_of(input logic [6:0] d);
    if (d >= 7'd65)      band_of = 2'd0;
    else if (d >= 7'd35) band_of = 2'd1;
    else if (d >= 7'd10) band_of = 2'd2;
    else                 band_of = 2'd3;
  endfunction

  logic sync1_q, sync2_q, lvl, lvl_prev_q, rise, edge_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= pwm_in;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic       f_q, f_d;
  logic [3:0] stab_q, stab_d;

  // The level only moves once the new value has been seen FILTER_LEN cycles in a row.
  always_comb begin
    f_d    = f_q;
    stab_d = 4'd0;
    if (sync2_q != f_q) begin
      if (stab_q == 4'(FILTER_LEN - 1)) f_d = sync2_q;
      else                              stab_d = stab_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= 1'b0;
      stab_q <= 4'd0;
    end else begin
      f_q    <= f_d;
      stab_q <= stab_d;
    end
  end

  assign lvl = f_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise     = lvl & ~lvl_prev_q;
  assign edge_any = lvl ^ lvl_prev_q;

  logic [CNT_W-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d, idle_q, idle_d;
  logic             to_fired_q, to_fired_d, timeout_hit;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d, h_q, h_d;
  logic [DW-1:0]    rem_q, rem_d, dsh_q, dsh_d;
  logic [6:0]       quo_q, quo_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [6:0]       duty_q, duty_d;
  logic [1:0]       band_q, band_d;
  logic             valid_q, valid_d, sh_q, sh_d, sl_q, sl_d;

  always_comb begin
    cnt_p_d = rise ? CNT_W'(1) : (cnt_p_q == CNT_MAX) ? cnt_p_q : cnt_p_q + CNT_W'(1);
    cnt_h_d = rise ? CNT_W'(1) : (lvl && cnt_h_q != CNT_MAX) ? cnt_h_q + CNT_W'(1) : cnt_h_q;
    idle_d  = edge_any ? '0 : (idle_q == TO_VAL) ? idle_q : idle_q + CNT_W'(1);
    // Deferred while the divider owns the outputs; fires once per quiet stretch.
    timeout_hit = (idle_q == TO_VAL) && !to_fired_q && !edge_any &&
                  (state_q != ST_DIVIDE) && (state_q != ST_DONE);
    to_fired_d  = edge_any ? 1'b0 : (timeout_hit | to_fired_q);
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    h_d      = h_q;
    rem_d    = rem_q;
    dsh_d    = dsh_q;
    quo_d    = quo_q;
    step_d   = step_q;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    band_d   = band_q;
    valid_d  = 1'b0;
    sh_d     = sh_q;
    sl_d     = sl_q;
    case (state_q)
      ST_WAIT_RISE: if (rise) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (rise && cnt_p_q >= CNT_W'(2)) begin
          p_d     = cnt_p_q;
          h_d     = cnt_h_q;
          rem_d   = DW'(cnt_h_q) * DW'(100);
          dsh_d   = {1'b0, cnt_p_q, 6'd0};
          quo_d   = 7'd0;
          step_d  = 3'd0;
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        // Restoring division: one quotient bit per cycle, divisor walks from P<<6 down to P.
        if (rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          quo_d = {quo_q[5:0], 1'b1};
        end else begin
          quo_d = {quo_q[5:0], 1'b0};
        end
        dsh_d  = dsh_q >> 1;
        step_d = step_q + 3'd1;
        if (step_q == 3'd6) begin
          state_d  = ST_DONE;
          period_d = p_q;
          high_d   = h_q;
          duty_d   = quo_d;
          band_d   = band_of(quo_d);
          valid_d  = 1'b1;
          sh_d     = 1'b0;
          sl_d     = 1'b0;
        end
      end
      default: state_d = ST_MEASURE;
    endcase
    if (timeout_hit) begin
      state_d  = ST_WAIT_RISE;
      period_d = '0;
      high_d   = '0;
      valid_d  = 1'b1;
      sh_d     = lvl;
      sl_d     = ~lvl;
      duty_d   = lvl ? 7'd100 : 7'd0;
      band_d   = lvl ? 2'd0 : 2'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p_q    <= '0;
      cnt_h_q    <= '0;
      idle_q     <= '0;
      to_fired_q <= 1'b0;
      state_q    <= ST_WAIT_RISE;
      p_q        <= '0;
      h_q        <= '0;
      rem_q      <= '0;
      dsh_q      <= '0;
      quo_q      <= '0;
      step_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      duty_q     <= '0;
      band_q     <= '0;
      valid_q    <= 1'b0;
      sh_q       <= 1'b0;
      sl_q       <= 1'b0;
    end else begin
      cnt_p_q    <= cnt_p_d;
      cnt_h_q    <= cnt_h_d;
      idle_q     <= idle_d;
      to_fired_q <= to_fired_d;
      state_q    <= state_d;
      p_q        <= p_d;
      h_q        <= h_d;
      rem_q      <= rem_d;
      dsh_q      <= dsh_d;
      quo_q      <= quo_d;
      step_q     <= step_d;
      period_q   <= period_d;
      high_q     <= high_d;
      duty_q     <= duty_d;
      band_q     <= band_d;
      valid_q    <= valid_d;
      sh_q       <= sh_d;
      sl_q       <= sl_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign duty_pct   = duty_q;
  assign band       = band_q;
  assign valid      = valid_q;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;
  assign busy       = (state_q == ST_DIVIDE);

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: waveform segments feed a rise-level reference model and an expected queue.
module tb_pwm_duty_capture;
  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 3000;
  localparam int FILTER_LEN = 4;
  localparam int LONG       = TIMEOUT + 10;

  logic             clk = 1'b0;
  logic             rst, pwm_in;
  logic [CNT_W-1:0] period, high_time;
  logic [6:0]       duty_pct;
  logic [1:0]       band;
  logic             valid, stuck_high, stuck_low, busy;

  pwm_duty_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILTER_LEN(FILTER_LEN)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .high_time(high_time),
    .duty_pct(duty_pct), .band(band), .valid(valid), .stuck_high(stuck_high),
    .stuck_low(stuck_low), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [6:0]       duty;
    logic [1:0]       band;
    logic             sh;
    logic             sl;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0, tests_failed = 0;
  int   exp_total = 0, got_total = 0;
  int   t_now = 0, last_rise = 0, last_high = 0, last_cap = -1000;
  bit   armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int band_ref(input int d);
    if (d >= 65) return 0;
    if (d >= 35) return 1;
    if (d >= 10) return 2;
    return 3;
  endfunction

  task automatic push_cap(input int p, input int h);
    exp_t e;
    e.period = CNT_W'(p);
    e.high   = CNT_W'(h);
    e.duty   = 7'((h * 100) / p);
    e.band   = 2'(band_ref((h * 100) / p));
    e.sh     = 1'b0;
    e.sl     = 1'b0;
    exp_q.push_back(e);
    exp_total++;
  endtask

  task automatic push_stuck(input bit hi);
    exp_t e;
    e.period = '0;
    e.high   = '0;
    e.duty   = hi ? 7'd100 : 7'd0;
    e.band   = hi ? 2'd0 : 2'd3;
    e.sh     = hi;
    e.sl     = ~hi;
    exp_q.push_back(e);
    exp_total++;
  endtask

  // Reference: one call per pulse (h high cycles then l low cycles), reasoned at the rising edge.
  task automatic model_seg(input int h, input int l);
    if (!armed) armed = 1'b1;
    else if (t_now - last_cap > 8) begin
      push_cap(t_now - last_rise, last_high);
      last_cap = t_now;
    end
    last_rise = t_now;
    last_high = h;
    if (h >= LONG) begin push_stuck(1'b1); armed = 1'b0; end
    if (l >= LONG) begin push_stuck(1'b0); armed = 1'b0; end
    t_now += h + l;
  endtask

  task automatic drive_level(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_seg(input int h, input int l);
    model_seg(h, l);
    drive_level(1'b1, h);
    drive_level(1'b0, l);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_high"}, 32'(high_time), 0);
    check({tag, "_duty"}, 32'(duty_pct), 0);
    check({tag, "_band"}, 32'(band), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_sh"}, 32'(stuck_high), 0);
    check({tag, "_sl"}, 32'(stuck_low), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  exp_t sb_e;
  always @(negedge clk) begin
    if (!rst && valid) begin
      got_total++;
      if (exp_q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        check("period", 32'(period), 32'(sb_e.period));
        check("high_time", 32'(high_time), 32'(sb_e.high));
        check("duty_pct", 32'(duty_pct), 32'(sb_e.duty));
        check("band", 32'(band), 32'(sb_e.band));
        check("stuck_high", 32'(stuck_high), 32'(sb_e.sh));
        check("stuck_low", 32'(stuck_low), 32'(sb_e.sl));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int h, l;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    drive_level(1'b0, 20);

    drive_seg(799, 201);
    drive_seg(799, 201);
    drive_seg(499, 501);
    drive_seg(199, 801);
    drive_seg(500, 500);

    drive_seg(500, LONG);
    drive_seg(500, 500);
    drive_seg(500, 500);
    drive_seg(500, 500);

    drive_seg(LONG, 500);
    drive_seg(500, 500);
    drive_seg(500, 500);
    drive_seg(500, 500);

    drive_seg(4, 4);
    drive_seg(300, 300);
    drive_seg(5, 4);
    drive_seg(300, 300);
`ifndef PWM_GLITCH_FILTER_EN
    drive_seg(2, 3);
    drive_seg(300, 300);
`endif

    drive_seg(500, 500);
`ifdef PWM_GLITCH_FILTER_EN
    model_seg(499, 501);
`else
    model_seg(300, 2);
    model_seg(197, 501);
`endif
    drive_level(1'b1, 300);
    drive_level(1'b0, 2);
    drive_level(1'b1, 197);
    drive_level(1'b0, 501);
    drive_seg(500, 500);
    drive_seg(500, 500);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        h = $urandom_range(4, 6);
        l = $urandom_range(4, 6);
      end else begin
        h = $urandom_range(5, 300);
        l = $urandom_range(5, 300);
      end
      drive_seg(h, l);
    end
    drive_seg(500, 500);
    drive_seg(500, 500);

    check("q_empty_pre_rst", 32'(exp_q.size()), 0);
    pwm_in = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 2) pwm_in = 1'b0;
      if (busy) seen = 1'b1;
    end
    pwm_in = 1'b0;
    check("busy_seen", 32'(seen), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst       = 1'b0;
    armed     = 1'b0;
    t_now    += 100;
    drive_level(1'b0, 100);
    drive_seg(500, 500);
    drive_seg(250, 750);
    drive_seg(500, 500);
    drive_level(1'b0, 200);

    check("q_drained", 32'(exp_q.size()), 0);
    check("valid_count", 32'(got_total), 32'(exp_total));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
